booth_mul_arbiter: RTL and testbench

//  Shares one pipelined booth_multiplier (fixed LATENCY, no stall, no valid) between NREQ requesters.

---
 rtl/booth_mul_arbiter.sv | 135 +++++++++++++
 tb/tb_booth_mul_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin sharing of one pipelined booth multiplier among NREQ requesters
// Optional per-requester issue counters when BOOTH_ARB_PERF_EN is defined.
module booth_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 5,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [31:0]          mul_multiplicand,
    output logic [31:0]          mul_multiplier,
    input  logic [63:0]          mul_result,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_result,
    output logic                 busy
`ifdef BOOTH_ARB_PERF_EN
    ,
    output logic [NREQ*16-1:0]   perf_issue_cnt
`endif
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   cand;
    logic [31:0]    mc_q, mc_d;
    logic [31:0]    mp_q, mp_d;

    // Stage 0 sits alongside the operand registers; stage LATENCY lines up with mul_result.
    logic [LATENCY:0] tag_vld_q;
    logic [IDW-1:0]   tag_id_q [0:LATENCY];

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        ptr_d     = ptr_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        if (gnt_found) begin
            req_ready[gnt_id] = 1'b1;
            ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_found && gnt_id == IDW'(k)) begin
                mc_d = req_a[32*k +: 32];
                mp_d = req_b[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
            mc_q  <= '0;
            mp_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            mc_q  <= mc_d;
            mp_q  <= mp_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_vld_q <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_vld_q   <= {tag_vld_q[LATENCY-1:0], gnt_found};
            tag_id_q[0] <= gnt_found ? gnt_id : '0;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_id    = '0;
        if (tag_vld_q[LATENCY]) begin
            rsp_valid[tag_id_q[LATENCY]] = 1'b1;
            rsp_id                       = tag_id_q[LATENCY];
        end
    end

    assign mul_multiplicand = mc_q;
    assign mul_multiplier   = mp_q;
    assign rsp_result       = mul_result;
    assign busy             = |tag_vld_q;

`ifdef BOOTH_ARB_PERF_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_perf
        logic [15:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (gnt_found && gnt_id == IDW'(i) && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign perf_issue_cnt[16*i +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter with a behavioural multiplier
module tb_booth_mul_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 5;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a = '0;
    logic [NREQ*32-1:0]   req_b = '0;
    logic [31:0]          mul_multiplicand;
    logic [31:0]          mul_multiplier;
    logic [63:0]          mul_result;
    logic [NREQ-1:0]      rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [63:0]          rsp_result;
    logic                 busy;
`ifdef BOOTH_ARB_PERF_EN
    logic [NREQ*16-1:0]   perf_issue_cnt;
`endif

    always #5 clk = ~clk;

    booth_mul_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .IDW(IDW)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_result       (mul_result),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_result       (rsp_result),
        .busy             (busy)
`ifdef BOOTH_ARB_PERF_EN
        ,
        .perf_issue_cnt   (perf_issue_cnt)
`endif
    );

    // Multiplier stand-in: LAT register stages fed straight from the operand registers.
    logic [63:0] mpipe [0:LAT-1];
    initial for (int k = 0; k < LAT; k++) mpipe[k] = '0;
    always @(posedge clk) begin
        mpipe[0] <= longint'($signed(mul_multiplicand)) * longint'($signed(mul_multiplier));
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = mpipe[LAT-1];

    typedef struct {
        int          id;
        logic [63:0] p;
    } rsp_t;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    rsp_t        exp_q [int];
    rsp_t        mon_e;
    logic [31:0] a_r [NREQ];
    logic [31:0] b_r [NREQ];
    logic [31:0] exp_mc = '0;
    logic [31:0] exp_mp = '0;
    vec_t        vecs [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    always @(negedge clk) begin
        if (exp_q.exists(cyc)) begin
            mon_e = exp_q[cyc];
            chk("rsp_valid", {60'd0, rsp_valid}, 64'(4'b0001 << mon_e.id));
            chk("rsp_id", {62'd0, rsp_id}, 64'(mon_e.id));
            chk("rsp_result", rsp_result, mon_e.p);
            exp_q.delete(cyc);
        end else begin
            chk("rsp_idle", {58'd0, rsp_id, rsp_valid}, 64'd0);
        end
    end

    task automatic step(input logic [3:0] v, input logic [3:0] exp_rdy, input string nm,
                        input logic ovr, input logic [63:0] ovr_p);
        int   g;
        rsp_t e;
        req_valid = v;
        for (int k = 0; k < NREQ; k++) begin
            req_a[32*k +: 32] = a_r[k];
            req_b[32*k +: 32] = b_r[k];
        end
        @(negedge clk);
        chk({nm, " ready"}, {60'd0, req_ready}, {60'd0, exp_rdy});
        g = -1;
        for (int k = 0; k < NREQ; k++) if (exp_rdy[k]) g = k;
        if (g >= 0) begin
            e.id = g;
            e.p  = ovr ? ovr_p : prod(a_r[g], b_r[g]);
            exp_q[cyc + 1 + LAT] = e;
            exp_mc = a_r[g];
            exp_mp = b_r[g];
            a_r[g] = $urandom;
            b_r[g] = $urandom;
        end
        @(posedge clk);
        #1;
        chk({nm, " mcand"}, {32'd0, mul_multiplicand}, {32'd0, exp_mc});
        chk({nm, " mplier"}, {32'd0, mul_multiplier}, {32'd0, exp_mp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, "idle", 1'b0, 64'd0);
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            a_r[k] = 32'(k + 3);
            b_r[k] = 32'(k + 11);
        end
        // Arbitration table, starting from ptr=0; expected grants worked out by hand.
        vecs[0]  = '{4'b0000, 4'b0000};
        vecs[1]  = '{4'b0100, 4'b0100};
        vecs[2]  = '{4'b1111, 4'b1000};
        vecs[3]  = '{4'b1111, 4'b0001};
        vecs[4]  = '{4'b1111, 4'b0010};
        vecs[5]  = '{4'b1111, 4'b0100};
        vecs[6]  = '{4'b0011, 4'b0001};
        vecs[7]  = '{4'b0011, 4'b0010};
        vecs[8]  = '{4'b1001, 4'b1000};
        vecs[9]  = '{4'b0000, 4'b0000};
        vecs[10] = '{4'b0110, 4'b0010};
        vecs[11] = '{4'b0010, 4'b0010};
        vecs[12] = '{4'b0110, 4'b0100};
        vecs[13] = '{4'b1000, 4'b1000};
        vecs[14] = '{4'b0101, 4'b0001};
        vecs[15] = '{4'b0101, 4'b0100};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset mcand", {32'd0, mul_multiplicand}, 64'd0);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 4'b0000, "idle10", 1'b0, 64'd0);
            chk("idle busy", {63'd0, busy}, 64'd0);
        end

        a_r[2] = 32'd7;
        b_r[2] = 32'hFFFF_FFFD;
        step(4'b0100, 4'b0100, "single", 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("single busy", {63'd0, busy}, 64'd1);
        idle(8);

        step(4'b0001, 4'b0001, "inflight0", 1'b0, 64'd0);
        step(4'b0010, 4'b0010, "inflight1", 1'b0, 64'd0);
        step(4'b0100, 4'b0100, "inflight2", 1'b0, 64'd0);
        chk("inflight busy", {63'd0, busy}, 64'd1);
        rstn = 1'b0;
        exp_q.delete();
        exp_mc = '0;
        exp_mp = '0;
        @(negedge clk);
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst mcand", {32'd0, mul_multiplicand}, 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(8);
        chk("post-rst busy", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'(4'b0001 << (i % 4)), "all4", 1'b0, 64'd0);
        end

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].valid, vecs[i].exp_ready, $sformatf("vec%0d", i), 1'b0, 64'd0);
        end
        idle(8);

        for (int i = 0; i < 20; i++) begin
            a_r[1] = (i == 0) ? 32'h8000_0000 : $random;
            b_r[1] = (i == 0) ? 32'h8000_0000 : $random;
            step(4'b0010, 4'b0010, "stream", i == 0, 64'h4000_0000_0000_0000);
        end
        idle(8);
        chk("stream busy", {63'd0, busy}, 64'd0);

`ifdef BOOTH_ARB_PERF_EN
        rstn = 1'b0;
        exp_q.delete();
        exp_mc = '0;
        exp_mp = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("perf reset", {perf_issue_cnt}, 64'd0);
        for (int i = 0; i < 70000; i++) step(4'b0001, 4'b0001, "perf", 1'b0, 64'd0);
        idle(8);
        chk("perf cnt0", {48'd0, perf_issue_cnt[15:0]}, 64'h0000_0000_0000_FFFF);
        chk("perf others", {16'd0, perf_issue_cnt[63:16]}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
